// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: packet-aware 1:2 stream demux with registered outputs and per-packet channel lock.
// Optional per-channel packet counters enabled by defining DEMUX_PKT_CNT_EN.
module stream_demux_1x2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_sel,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    output logic              a_last,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic              b_last,
    input  logic              b_ready
`ifdef DEMUX_PKT_CNT_EN
    ,
    output logic [15:0]       a_pkt_cnt,
    output logic [15:0]       b_pkt_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, PKT_A, PKT_B} state_t;
    state_t state;
    logic dest, dest_valid, dest_ready, acc;
    always_comb begin
        dest       = (state == IDLE) ? in_sel : (state == PKT_A);
        dest_valid = dest ? a_valid : b_valid;
        dest_ready = dest ? a_ready : b_ready;
        in_ready   = ~dest_valid | dest_ready;
        acc        = in_valid & in_ready;
    end
    // the channel is latched on the first accepted beat and released on the last one
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (acc)
            state <= in_last ? IDLE : (state == IDLE) ? (in_sel ? PKT_A : PKT_B) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            a_data  <= '0;
        end else if (acc & dest) begin
            a_valid <= 1'b1;
            a_last  <= in_last;
            a_data  <= in_data;
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_last  <= 1'b0;
            b_data  <= '0;
        end else if (acc & ~dest) begin
            b_valid <= 1'b1;
            b_last  <= in_last;
            b_data  <= in_data;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end
`ifdef DEMUX_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_pkt_cnt <= '0;
            b_pkt_cnt <= '0;
        end else begin
            if (a_valid & a_ready & a_last) a_pkt_cnt <= a_pkt_cnt + 16'd1;
            if (b_valid & b_ready & b_last) b_pkt_cnt <= b_pkt_cnt + 16'd1;
        end
    end
`endif
endmodule
